shift_register_sipo: RTL

- Serial-in, parallel-out shift register. It is the receiving end of the multiplier's LSB-first serial bit stream.
- It collects 2*WORD_LENGTH serial bits, one bit per shift strobe, into a parallel word.
- When the word is complete it presents the word and pulses ready.
- It sits after the multiplier's serializing shift register and feeds the product/result register.

---
 rtl/shift_register_sipo_if.sv | 26 ++
 rtl/shift_register_sipo.sv | 109 ++++++++++
 2 files changed

// File: rtl/shift_register_sipo_if.sv
// Bus between the serial-to-parallel collector and its neighbours:
// serial strobe/data in, completed word plus status out.
interface shift_register_sipo_if #(
  parameter int WORD_LENGTH = 4
) ();
  localparam int OUT_LENGTH = 2 * WORD_LENGTH;
  localparam int CNT_W      = $clog2(OUT_LENGTH) + 1;

  logic                  start;
  logic                  shift;
  logic                  data_in;
  logic [OUT_LENGTH-1:0] data_out;
  logic                  ready;
  logic                  busy;
  logic [CNT_W-1:0]      bit_count;

  modport master (
    output start, shift, data_in,
    input  data_out, ready, busy, bit_count
  );

  modport slave (
    input  start, shift, data_in,
    output data_out, ready, busy, bit_count
  );
endinterface

// File: rtl/shift_register_sipo.sv
// Serial-in parallel-out collector for the multiplier's 2*WORD_LENGTH-bit stream.
// Default is LSB first; define SIPO_MSB_FIRST_EN for MSB-first collection.
module shift_register_sipo #(
  parameter int WORD_LENGTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_register_sipo_if.slave  sif
);
  localparam int OUT_LENGTH = 2 * WORD_LENGTH;
  localparam int CNT_W      = $clog2(OUT_LENGTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  // The bit that would shift out of the far end is never used, so only
  // OUT_LENGTH-1 received bits are stored; the final bit goes straight out.
  logic [OUT_LENGTH-2:0] r_shreg;
  logic [OUT_LENGTH-2:0] w_shreg_next;
  logic [OUT_LENGTH-1:0] r_data_out;
  logic [OUT_LENGTH-1:0] w_data_out_next;
  logic [CNT_W-1:0]      r_bit_count;
  logic [CNT_W-1:0]      w_bit_count_next;
  logic [OUT_LENGTH-1:0] w_word;
  logic [OUT_LENGTH-2:0] w_shreg_shifted;
  logic                  w_last_bit;

`ifdef SIPO_MSB_FIRST_EN
  assign w_word          = {r_shreg, sif.data_in};
  assign w_shreg_shifted = w_word[OUT_LENGTH-2:0];
`else
  assign w_word          = {sif.data_in, r_shreg};
  assign w_shreg_shifted = w_word[OUT_LENGTH-1:1];
`endif

  assign w_last_bit = (r_bit_count == CNT_W'(OUT_LENGTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_data_out  <= '0;
      r_bit_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_shreg     <= w_shreg_next;
      r_data_out  <= w_data_out_next;
      r_bit_count <= w_bit_count_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_shreg_next     = r_shreg;
    w_data_out_next  = r_data_out;
    w_bit_count_next = r_bit_count;

    case (r_state)
      S_IDLE: begin
        if (sif.start) begin
          w_state_next     = S_COLLECT;
          w_shreg_next     = '0;
          w_bit_count_next = '0;
        end
      end

      S_COLLECT: begin
        // start beats shift: a restart discards the bit on the same edge
        if (sif.start) begin
          w_shreg_next     = '0;
          w_bit_count_next = '0;
        end else if (sif.shift) begin
          w_shreg_next = w_shreg_shifted;
          if (w_last_bit) begin
            w_data_out_next  = w_word;
            w_bit_count_next = '0;
            w_state_next     = S_DONE;
          end else begin
            w_bit_count_next = r_bit_count + CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
        if (sif.start) begin
          w_state_next     = S_COLLECT;
          w_shreg_next     = '0;
          w_bit_count_next = '0;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign sif.data_out  = r_data_out;
  assign sif.ready     = (r_state == S_DONE);
  assign sif.busy      = (r_state == S_COLLECT);
  assign sif.bit_count = r_bit_count;

endmodule
